// File: rtl/pipe_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: state encodings and the
// destination scoreboard entry layout.
package pipe_hazard_controller_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SB_DEPTH = 3;

  localparam int unsigned SB_EXE = 0;
  localparam int unsigned SB_MEM = 1;
  localparam int unsigned SB_WB  = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZARD = 2'd1,
    ST_FREEZE = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             load;
  } sb_entry_t;

  localparam int unsigned SB_ENTRY_W = $bits(sb_entry_t);
  localparam sb_entry_t   SB_EMPTY   = sb_entry_t'(SB_ENTRY_W'(0));

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against one scoreboard entry.
module hazard_match
  import pipe_hazard_controller_pkg::*;
(
  input  logic             i_uses,
  input  logic [REG_W-1:0] i_src,
  input  logic             i_valid,
  input  logic [REG_W-1:0] i_dest,
  output logic             o_match_c
);

  // $0 is never a real dependency on either side
  assign o_match_c = i_uses & (i_src != '0) & i_valid & (i_dest != '0) & (i_dest == i_src);

endmodule

// File: rtl/pipe_hazard_controller.sv
// Stall/freeze/flush control for a 5-stage pipeline, driven by a small
// EXE/MEM/WB destination scoreboard.
module pipe_hazard_controller
  import pipe_hazard_controller_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic [REG_W-1:0] ID_dest,
  input  logic             ID_reg_write,
  input  logic             ID_load,
  input  logic             ID_resolve,
  input  logic             ID_taken,
  input  logic             MEM_busy,
  output logic             PC_enable,
  output logic             IFID_enable,
  output logic             IDEXE_bubble,
  output logic             IFID_flush,
  output logic             PIPE_freeze,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STALL_count
);

  sb_entry_t        r_sb [SB_DEPTH];
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [REG_W-1:0] w_src  [2];
  logic             w_uses [2];
  logic             w_match [2][SB_DEPTH];
  logic             w_exe_hit;
  logic             w_mem_hit;
  logic             w_load_use;
  logic             w_branch_haz;
  logic             w_hazard;

  assign w_src[0]  = ID_rs;
  assign w_src[1]  = ID_rt;
  assign w_uses[0] = ID_uses_rs;
  assign w_uses[1] = ID_uses_rt;

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar e = 0; e < SB_DEPTH; e++) begin : g_ent
      hazard_match u_match (
        .i_uses    (w_uses[s]),
        .i_src     (w_src[s]),
        .i_valid   (r_sb[e].valid),
        .i_dest    (r_sb[e].dest),
        .o_match_c (w_match[s][e])
      );
    end
  end

  // WB matches are covered by forwarding and never stall
  assign w_exe_hit    = w_match[0][SB_EXE] | w_match[1][SB_EXE];
  assign w_mem_hit    = w_match[0][SB_MEM] | w_match[1][SB_MEM];
  assign w_load_use   = w_exe_hit & r_sb[SB_EXE].load;
  assign w_branch_haz = ID_resolve & (w_exe_hit | (w_mem_hit & r_sb[SB_MEM].load));
  assign w_hazard     = w_load_use | w_branch_haz;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory stall outranks hazard stall, which outranks normal advance
  always_comb begin
    w_state_nxt  = ST_RUN;
    PC_enable    = 1'b1;
    IFID_enable  = 1'b1;
    IDEXE_bubble = 1'b0;
    IFID_flush   = 1'b0;
    PIPE_freeze  = 1'b0;
    if (MEM_busy) begin
      w_state_nxt = ST_FREEZE;
      PC_enable   = 1'b0;
      IFID_enable = 1'b0;
      PIPE_freeze = 1'b1;
    end else if (w_hazard) begin
      w_state_nxt  = ST_HAZARD;
      PC_enable    = 1'b0;
      IFID_enable  = 1'b0;
      IDEXE_bubble = 1'b1;
    end else begin
      IFID_flush = ID_resolve & ID_taken;
    end
  end

  assign STATE       = r_state;
  assign STALL_count = r_stall_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_stall_cnt <= '0;
    end else if ((MEM_busy | w_hazard) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Scoreboard holds on freeze; a hazard inserts an empty slot into EXE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        r_sb[i] <= SB_EMPTY;
      end
    end else if (!MEM_busy) begin
      r_sb[SB_WB]  <= r_sb[SB_MEM];
      r_sb[SB_MEM] <= r_sb[SB_EXE];
      r_sb[SB_EXE] <= w_hazard ? SB_EMPTY : {ID_reg_write, ID_dest, ID_load};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Bench for pipe_hazard_controller: directed scenarios plus random traffic,
// all checked against an instruction-level model of the in-flight writers.
module tb_pipe_hazard_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] ID_rs, ID_rt, ID_dest;
  logic       ID_uses_rs, ID_uses_rt, ID_reg_write, ID_load, ID_resolve, ID_taken, MEM_busy;
  logic       PC_enable, IFID_enable, IDEXE_bubble, IFID_flush, PIPE_freeze;
  logic [1:0] STATE;
  logic [15:0] STALL_count;

  typedef struct packed {
    logic [4:0] rs, rt, dest;
    logic       urs, urt, rw, ld, res, tk, busy;
  } stim_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Destination (0 = none) and load flag of the instructions in EXE, MEM, WB
  int q_dest [3];
  bit q_load [3];
  int exp_state;
  int exp_cnt;

  always #5 CLK = ~CLK;

  pipe_hazard_controller dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_uses_rs   (ID_uses_rs),
    .ID_uses_rt   (ID_uses_rt),
    .ID_dest      (ID_dest),
    .ID_reg_write (ID_reg_write),
    .ID_load      (ID_load),
    .ID_resolve   (ID_resolve),
    .ID_taken     (ID_taken),
    .MEM_busy     (MEM_busy),
    .PC_enable    (PC_enable),
    .IFID_enable  (IFID_enable),
    .IDEXE_bubble (IDEXE_bubble),
    .IFID_flush   (IFID_flush),
    .PIPE_freeze  (PIPE_freeze),
    .STATE        (STATE),
    .STALL_count  (STALL_count)
  );

  function automatic stim_t s_nop(bit busy);
    stim_t s = '0;
    s.busy = busy;
    return s;
  endfunction

  function automatic stim_t s_lw(int d);
    stim_t s = '0;
    s.dest = 5'(d); s.rw = 1'b1; s.ld = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_alu(int d, int a, int b, bit busy);
    stim_t s = '0;
    s.dest = 5'(d); s.rw = 1'b1; s.rs = 5'(a); s.rt = 5'(b);
    s.urs = 1'b1; s.urt = 1'b1; s.busy = busy;
    return s;
  endfunction

  function automatic stim_t s_br(int a, int b, bit tk);
    stim_t s = '0;
    s.rs = 5'(a); s.rt = 5'(b); s.urs = 1'b1; s.urt = 1'b1;
    s.res = 1'b1; s.tk = tk;
    return s;
  endfunction

  function automatic bit hit(bit u, int src, int slot);
    return u && (src != 0) && (q_dest[slot] == src);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      q_dest[i] = 0;
      q_load[i] = 1'b0;
    end
    exp_state = 0;
    exp_cnt   = 0;
  endtask

  task automatic drive(input stim_t s);
    ID_rs = s.rs; ID_rt = s.rt; ID_dest = s.dest;
    ID_uses_rs = s.urs; ID_uses_rt = s.urt; ID_reg_write = s.rw;
    ID_load = s.ld; ID_resolve = s.res; ID_taken = s.tk; MEM_busy = s.busy;
  endtask

  // One clock: drive, observe mid-cycle, then advance the model at the edge
  task automatic cyc(input stim_t s, output logic [22:0] o, output logic [22:0] e);
    bit exe_h, mem_h, haz;
    logic [4:0] flags;
    drive(s);
    #2;
    exe_h = hit(s.urs, int'(s.rs), 0) || hit(s.urt, int'(s.rt), 0);
    mem_h = hit(s.urs, int'(s.rs), 1) || hit(s.urt, int'(s.rt), 1);
    haz   = (exe_h && q_load[0]) || (s.res && (exe_h || (mem_h && q_load[1])));
    if (s.busy)   flags = 5'b00001;
    else if (haz) flags = 5'b00100;
    else          flags = {1'b1, 1'b1, 1'b0, s.res & s.tk, 1'b0};
    e = {flags, 2'(exp_state), 16'(exp_cnt)};
    o = {PC_enable, IFID_enable, IDEXE_bubble, IFID_flush, PIPE_freeze, STATE, STALL_count};
    @(posedge CLK);
    if (!s.busy) begin
      q_dest[2] = q_dest[1]; q_load[2] = q_load[1];
      q_dest[1] = q_dest[0]; q_load[1] = q_load[0];
      q_dest[0] = (haz || !s.rw) ? 0 : int'(s.dest);
      q_load[0] = !haz && s.ld;
    end
    exp_state = s.busy ? 2 : (haz ? 1 : 0);
    if ((s.busy || haz) && exp_cnt < 65535) exp_cnt++;
    #1;
  endtask

  task automatic test_reset();
    drive(s_nop(1'b0));
    RESET = 1'b0;
    #3;
    n_chk++;
    if ({PC_enable, IFID_enable, IDEXE_bubble, IFID_flush, PIPE_freeze} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 11000",
               {PC_enable, IFID_enable, IDEXE_bubble, IFID_flush, PIPE_freeze});
    end
    n_chk++;
    if ({STATE, STALL_count} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got state %0d count %0d expected 0 0", STATE, STALL_count);
    end
    MEM_busy = 1'b1;
    #1;
    n_chk++;
    if ({PC_enable, IFID_enable, IDEXE_bubble, IFID_flush, PIPE_freeze} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 00001",
               {PC_enable, IFID_enable, IDEXE_bubble, IFID_flush, PIPE_freeze});
    end
    MEM_busy = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    model_clear();
  endtask

  task automatic test_load_use();
    stim_t seq [$];
    logic [22:0] o, e;
    int bubbles = 0;
    seq = '{s_nop(0), s_nop(0), s_nop(0), s_lw(5), s_alu(6, 5, 7, 0), s_alu(6, 5, 7, 0), s_nop(0)};
    foreach (seq[i]) begin
      cyc(seq[i], o, e);
      if (i >= 3) bubbles += int'(o[20]);
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL load_use c%0d: got %h expected %h", i, o, e); end
    end
    n_chk++;
    if (bubbles != 1) begin n_fail++; $display("FAIL load_use_bubbles: got %0d expected 1", bubbles); end
  endtask

  task automatic test_branch_load();
    stim_t seq [$];
    logic [22:0] o, e;
    int bubbles = 0;
    bit flushed = 1'b0;
    seq = '{s_nop(0), s_nop(0), s_nop(0), s_lw(5), s_br(5, 0, 1), s_br(5, 0, 1), s_br(5, 0, 1)};
    foreach (seq[i]) begin
      cyc(seq[i], o, e);
      if (i >= 3) bubbles += int'(o[20]);
      if (i == 6) flushed = o[19];
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL branch_load c%0d: got %h expected %h", i, o, e); end
    end
    n_chk++;
    if (bubbles != 2 || flushed !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_load_stall: got %0d bubbles flush %b expected 2 bubbles flush 1", bubbles, flushed);
    end
  endtask

  task automatic test_branch_alu();
    stim_t seq [$];
    logic [22:0] o, e;
    seq = '{s_nop(0), s_nop(0), s_nop(0), s_alu(3, 1, 2, 0), s_br(3, 4, 1), s_br(3, 4, 1), s_br(4, 3, 0)};
    foreach (seq[i]) begin
      cyc(seq[i], o, e);
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL branch_alu c%0d: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_freeze_mid_hazard();
    stim_t seq [$];
    logic [22:0] o, e;
    int freezes = 0;
    int c0 = 0;
    seq = '{s_nop(0), s_nop(0), s_nop(0), s_lw(5), s_alu(6, 5, 7, 1), s_alu(6, 5, 7, 1),
            s_alu(6, 5, 7, 1), s_alu(6, 5, 7, 0), s_alu(6, 5, 7, 0), s_nop(0)};
    foreach (seq[i]) begin
      cyc(seq[i], o, e);
      if (i == 4) c0 = int'(o[15:0]);
      if (i == 9) c0 = int'(o[15:0]) - c0;
      freezes += int'(o[18]);
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL freeze c%0d: got %h expected %h", i, o, e); end
    end
    n_chk++;
    if (freezes != 3 || c0 != 4) begin
      n_fail++;
      $display("FAIL freeze_totals: got %0d freezes +%0d stalls expected 3 freezes +4 stalls", freezes, c0);
    end
  endtask

  task automatic test_zero_dest();
    stim_t seq [$];
    logic [22:0] o, e;
    int bubbles = 0;
    seq = '{s_nop(0), s_nop(0), s_nop(0), s_lw(0), s_alu(6, 0, 0, 0), s_alu(0, 1, 2, 0), s_br(0, 0, 1)};
    foreach (seq[i]) begin
      cyc(seq[i], o, e);
      bubbles += int'(o[20]);
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL zero_dest c%0d: got %h expected %h", i, o, e); end
    end
    n_chk++;
    if (bubbles != 0) begin n_fail++; $display("FAIL zero_dest_bubbles: got %0d expected 0", bubbles); end
  endtask

  task automatic test_reset_mid_stall();
    stim_t seq [$];
    logic [22:0] o, e;
    seq = '{s_nop(0), s_nop(0), s_nop(0), s_lw(5), s_br(5, 0, 1)};
    foreach (seq[i]) begin
      cyc(seq[i], o, e);
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL rst_stall c%0d: got %h expected %h", i, o, e); end
    end
    drive(s_br(5, 0, 1));
    #2;
    n_chk++;
    if ({PC_enable, IDEXE_bubble, STATE} !== 4'b0101) begin
      n_fail++;
      $display("FAIL rst_stall_pre: got %b expected 0101", {PC_enable, IDEXE_bubble, STATE});
    end
    RESET = 1'b0;
    #1;
    n_chk++;
    if (STATE !== 2'd0 || STALL_count !== 16'd0 || PC_enable !== 1'b1 || IDEXE_bubble !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall_async: got state %0d count %0d pc %b bubble %b expected 0 0 1 0",
               STATE, STALL_count, PC_enable, IDEXE_bubble);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    model_clear();
  endtask

  task automatic test_random();
    stim_t s;
    logic [22:0] o, e;
    for (int i = 0; i < 400; i++) begin
      s.rs   = 5'($urandom_range(0, 7));
      s.rt   = 5'($urandom_range(0, 7));
      s.dest = 5'($urandom_range(0, 7));
      s.urs  = 1'($urandom_range(0, 1));
      s.urt  = 1'($urandom_range(0, 1));
      s.rw   = 1'($urandom_range(0, 1));
      s.ld   = 1'($urandom_range(0, 1));
      s.res  = ($urandom_range(0, 3) == 0);
      s.tk   = 1'($urandom_range(0, 1));
      s.busy = ($urandom_range(0, 5) == 0);
      cyc(s, o, e);
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL random c%0d: got %h expected %h", i, o, e); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_freeze_mid_hazard();
    test_zero_dest();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
